// File: rtl/bitwise_chk_pkg.sv
// ============================================================================
//  Module      : bitwise_chk_pkg
//  Description : Shared types and helpers for the bitwise sweep checker.
//                Holds the FSM state encoding, the response-mask bit indices
//                and the golden-value function for the `bitwise` unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bitwise_chk_pkg;

    // State encodings. The enum below is built on these values so that
    // legacy code can keep comparing against plain 3-bit constants.
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_DRIVE  = 3'd1;
    localparam logic [2:0] c_ST_SETTLE = 3'd2;
    localparam logic [2:0] c_ST_CHECK  = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = c_ST_IDLE,
        DRIVE  = c_ST_DRIVE,
        SETTLE = c_ST_SETTLE,
        CHECK  = c_ST_CHECK,
        DONE   = c_ST_DONE
    } state_t;

    // Bit positions inside the 5-bit response / mismatch vectors.
    localparam int c_BIT_A_INV   = 0;
    localparam int c_BIT_B_INV   = 1;
    localparam int c_BIT_A_AND_B = 2;
    localparam int c_BIT_A_OR_B  = 3;
    localparam int c_BIT_A_XOR_B = 4;

    localparam int c_RESP_W = 5;

    // Expected response of the `bitwise` unit for one input pair.
    function automatic logic [c_RESP_W-1:0] bitwise_golden(input logic a, input logic b);
        logic [c_RESP_W-1:0] v;
        v                = '0;
        v[c_BIT_A_INV]   = ~a;
        v[c_BIT_B_INV]   = ~b;
        v[c_BIT_A_AND_B] = a & b;
        v[c_BIT_A_OR_B]  = a | b;
        v[c_BIT_A_XOR_B] = a ^ b;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//                Clear has priority over increment.
//  Ports       : clk      - clock, rising edge
//                rst_n    - synchronous active-low reset
//                i_clear  - synchronous clear to zero
//                i_inc    - increment by one (ignored when saturated)
//                o_count  - current count
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_MAX)) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/bitwise_sweep_checker.sv
// ============================================================================
//  Module      : bitwise_sweep_checker
//  Description : Self-checking stimulus/response wrapper for the combinational
//                `bitwise` unit. Sweeps a/b through 00,01,10,11 (a outer),
//                waits SETTLE_CYCLES, compares the five responses against
//                golden values derived from the registered a/b, and reports
//                pass/fail, a saturating error count and a sticky mask.
//  Parameters  : SETTLE_CYCLES (1..255), NUM_PASSES (1..255), ERR_W
//  Ports       : clk, rst_n (sync, active-low), start (pulse)
//                a, b                       - stimulus to bitwise
//                a_inv .. a_xor_b           - responses from bitwise
//                busy, done, pass           - status
//                err_count [ERR_W], err_mask [5] {xor,or,and,b_inv,a_inv}
//  Build macro : BITWISE_CHK_STOP_ON_FAIL_EN - when defined, the first CHECK
//                with any mismatch ends the run and a/b hold that vector.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitwise_sweep_checker
    import bitwise_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             a_inv,
    input  logic             b_inv,
    input  logic             a_and_b,
    input  logic             a_or_b,
    input  logic             a_xor_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [4:0]       err_mask
);

    localparam logic [7:0] c_SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] c_LAST_PASS   = 8'(NUM_PASSES - 1);

    state_t              r_state;
    logic [1:0]          r_idx;
    logic [7:0]          r_pass_cnt;
    logic [7:0]          r_settle_cnt;
    logic                r_a;
    logic                r_b;
    logic [c_RESP_W-1:0] r_err_mask;

    logic [c_RESP_W-1:0] w_observed;
    logic [c_RESP_W-1:0] w_diff;
    logic                w_any_mismatch;
    logic                w_start_ok;
    logic                w_check;
    logic                w_last_vec;
    logic                w_stop;
    logic [ERR_W-1:0]    w_err_count;

    always_comb begin
        w_observed                = '0;
        w_observed[c_BIT_A_INV]   = a_inv;
        w_observed[c_BIT_B_INV]   = b_inv;
        w_observed[c_BIT_A_AND_B] = a_and_b;
        w_observed[c_BIT_A_OR_B]  = a_or_b;
        w_observed[c_BIT_A_XOR_B] = a_xor_b;
    end

    // Golden values come from our own registered stimulus, never from the
    // unit under test, so a broken unit cannot mask its own faults.
    assign w_diff         = w_observed ^ bitwise_golden(r_a, r_b);
    assign w_any_mismatch = |w_diff;

    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_check    = (r_state == CHECK);
    assign w_last_vec = (r_idx == 2'd3) && (r_pass_cnt == c_LAST_PASS);

`ifdef BITWISE_CHK_STOP_ON_FAIL_EN
    assign w_stop = w_any_mismatch;
`else
    assign w_stop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= 2'd0;
            r_pass_cnt   <= 8'd0;
            r_settle_cnt <= 8'd0;
            r_a          <= 1'b0;
            r_b          <= 1'b0;
            r_err_mask   <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_start_ok) begin
                        r_err_mask <= '0;
                        r_idx      <= 2'd0;
                        r_pass_cnt <= 8'd0;
                        r_state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    r_a          <= r_idx[1];
                    r_b          <= r_idx[0];
                    r_settle_cnt <= c_SETTLE_LOAD;
                    r_state      <= SETTLE;
                end
                SETTLE: begin
                    // Loaded with SETTLE_CYCLES-1 so this state lasts
                    // exactly SETTLE_CYCLES cycles.
                    if (r_settle_cnt == 8'd0) begin
                        r_state <= CHECK;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 8'd1;
                    end
                end
                CHECK: begin
                    r_err_mask <= r_err_mask | w_diff;
                    if (w_last_vec || w_stop) begin
                        // a/b are left untouched so the last (or failing)
                        // vector stays visible.
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_pass_cnt <= r_pass_cnt + 8'd1;
                        end
                        r_state <= DRIVE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (ERR_W)
    ) u_err_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_start_ok),
        .i_inc   (w_check && w_any_mismatch),
        .o_count (w_err_count)
    );

    assign a         = r_a;
    assign b         = r_b;
    assign busy      = (r_state == DRIVE) || (r_state == SETTLE) || (r_state == CHECK);
    assign done      = (r_state == DONE);
    assign pass      = done && (w_err_count == '0);
    assign err_count = w_err_count;
    assign err_mask  = r_err_mask;

endmodule

`default_nettype wire

// File: tb/tb_bitwise_sweep_checker.sv
// ============================================================================
//  Module      : tb_bitwise_sweep_checker
//  Description : Directed bench for bitwise_sweep_checker. A behavioural
//                `bitwise` model with selectable faults feeds each instance.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bitwise_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_a;
    logic start_bc;
    int   fault_a;

    // Instance A: default parameters, fault selectable at run time.
    logic       a_a, b_a, busy_a, done_a, pass_a;
    logic [7:0] err_a;
    logic [4:0] mask_a;
    logic [4:0] resp_a;

    // Instance S3: NUM_PASSES=3, ERR_W=3, a_inv always wrong.
    logic       a_s3, b_s3, busy_s3, done_s3, pass_s3;
    logic [2:0] err_s3;
    logic [4:0] mask_s3;
    logic [4:0] resp_s3;

    // Instance N3: NUM_PASSES=3, ERR_W=8, a_inv always wrong.
    logic       a_n3, b_n3, busy_n3, done_n3, pass_n3;
    logic [7:0] err_n3;
    logic [4:0] mask_n3;
    logic [4:0] resp_n3;

    int n_assert = 0;
    int n_fail   = 0;

    // Fault codes: 0 none, 1 a_xor_b stuck 0, 2 a_inv inverted, 3 a_and_b stuck 1.
    // Return order {xor, or, and, b_inv, a_inv}.
    function automatic logic [4:0] bitwise_model(input logic ia, input logic ib, input int fault);
        logic [4:0] v;
        v = {ia ^ ib, ia | ib, ia & ib, ~ib, ~ia};
        case (fault)
            1:       v[4] = 1'b0;
            2:       v[0] = ~v[0];
            3:       v[2] = 1'b1;
            default: ;
        endcase
        return v;
    endfunction

    assign resp_a  = bitwise_model(a_a, b_a, fault_a);
    assign resp_s3 = bitwise_model(a_s3, b_s3, 2);
    assign resp_n3 = bitwise_model(a_n3, b_n3, 2);

    bitwise_sweep_checker u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_a),
        .a         (a_a),
        .b         (b_a),
        .a_inv     (resp_a[0]),
        .b_inv     (resp_a[1]),
        .a_and_b   (resp_a[2]),
        .a_or_b    (resp_a[3]),
        .a_xor_b   (resp_a[4]),
        .busy      (busy_a),
        .done      (done_a),
        .pass      (pass_a),
        .err_count (err_a),
        .err_mask  (mask_a)
    );

    bitwise_sweep_checker #(
        .SETTLE_CYCLES (2),
        .NUM_PASSES    (3),
        .ERR_W         (3)
    ) u_dut_s3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_bc),
        .a         (a_s3),
        .b         (b_s3),
        .a_inv     (resp_s3[0]),
        .b_inv     (resp_s3[1]),
        .a_and_b   (resp_s3[2]),
        .a_or_b    (resp_s3[3]),
        .a_xor_b   (resp_s3[4]),
        .busy      (busy_s3),
        .done      (done_s3),
        .pass      (pass_s3),
        .err_count (err_s3),
        .err_mask  (mask_s3)
    );

    bitwise_sweep_checker #(
        .SETTLE_CYCLES (2),
        .NUM_PASSES    (3),
        .ERR_W         (8)
    ) u_dut_n3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_bc),
        .a         (a_n3),
        .b         (b_n3),
        .a_inv     (resp_n3[0]),
        .b_inv     (resp_n3[1]),
        .a_and_b   (resp_n3[2]),
        .a_or_b    (resp_n3[3]),
        .a_xor_b   (resp_n3[4]),
        .busy      (busy_n3),
        .done      (done_n3),
        .pass      (pass_n3),
        .err_count (err_n3),
        .err_mask  (mask_n3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start on instance A, then count rising edges until done.
    // seq collects {a,b} just after each DRIVE edge (cycles 1,5,9,13).
    // poke re-pulses start mid-run to show it is ignored while busy.
    task automatic run_a(input bit poke, output int cycles, output logic [7:0] seq);
        seq    = 8'h00;
        cycles = 999;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        check("busy_after_start", busy_a, 1'b1);
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (n == 1)  seq[7:6] = {a_a, b_a};
            if (n == 5)  seq[5:4] = {a_a, b_a};
            if (n == 9)  seq[3:2] = {a_a, b_a};
            if (n == 13) seq[1:0] = {a_a, b_a};
            if (done_a) begin
                cycles = n;
                break;
            end
            start_a = poke && ((n == 3) || (n == 10));
        end
        start_a = 1'b0;
    endtask

    initial begin
        int         cyc;
        logic [7:0] seq;

        rst_n    = 1'b0;
        start_a  = 1'b0;
        start_bc = 1'b0;
        fault_a  = 0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_a",        a_a,    1'b0);
        check("rst_b",        b_a,    1'b0);
        check("rst_busy",     busy_a, 1'b0);
        check("rst_done",     done_a, 1'b0);
        check("rst_pass",     pass_a, 1'b0);
        check("rst_err",      err_a,  8'd0);
        check("rst_mask",     mask_a, 5'd0);
        check("rst_busy_n3",  busy_n3, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Clean sweep
        run_a(1'b0, cyc, seq);
        check("clean_cycles", cyc,    16);
        check("clean_seq",    seq,    8'h1B);
        check("clean_done",   done_a, 1'b1);
        check("clean_busy",   busy_a, 1'b0);
        check("clean_pass",   pass_a, 1'b1);
        check("clean_err",    err_a,  8'd0);
        check("clean_mask",   mask_a, 5'd0);

        // Restart from DONE with start pulses while busy
        run_a(1'b1, cyc, seq);
        check("poke_cycles",  cyc,    16);
        check("poke_seq",     seq,    8'h1B);
        check("poke_pass",    pass_a, 1'b1);

        // a_xor_b stuck at 0: wrong on 01 and 10
        fault_a = 1;
        run_a(1'b0, cyc, seq);
`ifdef BITWISE_CHK_STOP_ON_FAIL_EN
        check("xor_cycles",   cyc,            8);
        check("xor_err",      err_a,          8'd1);
        check("xor_ab",       {a_a, b_a},     2'b01);
`else
        check("xor_cycles",   cyc,            16);
        check("xor_err",      err_a,          8'd2);
        check("xor_ab",       {a_a, b_a},     2'b11);
`endif
        check("xor_mask",     mask_a,         5'b10000);
        check("xor_pass",     pass_a,         1'b0);
        check("xor_done",     done_a,         1'b1);

        // a_and_b stuck at 1: wrong on 00, 01, 10
        fault_a = 3;
        run_a(1'b0, cyc, seq);
`ifdef BITWISE_CHK_STOP_ON_FAIL_EN
        check("and_cycles",   cyc,            4);
        check("and_err",      err_a,          8'd1);
        check("and_ab",       {a_a, b_a},     2'b00);
`else
        check("and_cycles",   cyc,            16);
        check("and_err",      err_a,          8'd3);
        check("and_ab",       {a_a, b_a},     2'b11);
`endif
        check("and_mask",     mask_a,         5'b00100);
        check("and_pass",     pass_a,         1'b0);

        // Reset during the second vector's settle window
        fault_a = 2;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_a",     a_a,    1'b0);
        check("midrst_b",     b_a,    1'b0);
        check("midrst_busy",  busy_a, 1'b0);
        check("midrst_done",  done_a, 1'b0);
        check("midrst_pass",  pass_a, 1'b0);
        check("midrst_err",   err_a,  8'd0);
        check("midrst_mask",  mask_a, 5'd0);
        @(posedge clk);
        #1;
        check("midrst_idle",  busy_a, 1'b0);

        fault_a = 0;
        run_a(1'b0, cyc, seq);
        check("after_rst_cycles", cyc,    16);
        check("after_rst_seq",    seq,    8'h1B);
        check("after_rst_pass",   pass_a, 1'b1);
        check("after_rst_err",    err_a,  8'd0);

        // start coincident with reset: reset wins
        rst_n   = 1'b0;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        start_a = 1'b0;
        rst_n   = 1'b1;
        check("rst_start_busy", busy_a, 1'b0);
        check("rst_start_done", done_a, 1'b0);
        @(posedge clk);
        #1;
        check("rst_start_idle", busy_a, 1'b0);

        // Three passes with a_inv always wrong; ERR_W=3 saturates at 7
        @(negedge clk);
        start_bc = 1'b1;
        @(posedge clk);
        #1;
        start_bc = 1'b0;
        cyc = 999;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            if (done_n3) begin
                cyc = n;
                break;
            end
        end
`ifdef BITWISE_CHK_STOP_ON_FAIL_EN
        check("np3_cycles",  cyc,    4);
        check("np3_err",     err_n3, 8'd1);
        check("sat_err",     err_s3, 3'd1);
`else
        check("np3_cycles",  cyc,    48);
        check("np3_err",     err_n3, 8'd12);
        check("sat_err",     err_s3, 3'd7);
`endif
        check("np3_mask",    mask_n3, 5'b00001);
        check("np3_pass",    pass_n3, 1'b0);
        check("sat_mask",    mask_s3, 5'b00001);
        check("sat_done",    done_s3, 1'b1);
        check("sat_pass",    pass_s3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
